mcpu_ctrl_fsm: RTL and testbench

Multicycle control unit for the MIPS-subset CPU. It decodes the latched instruction and sequences the shared datapath (PC, memory port, IR, register file, the single ALU) one state per clock. It drives the ALU's 6-bit `func` input directly with the same codes the ALU decodes. It sits between the instruction register / ALU flags and every datapath mux and write-enable.

---
 rtl/mcpu_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-subset CPU.
// Sequences PC, memory, IR, regfile and the shared ALU one state per clock.
module mcpu_ctrl_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_func,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  state_t state_q, state_d;
  logic   run_q, run_d;
  logic   r_alu, is_shift;
  logic   is_r, is_mem, is_br;

  // run_q holds everything idle for the first cycle after reset release
  assign run_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    r_alu    = 1'b0;
    is_shift = 1'b0;
    case (funct)
      F_ADD, F_SUB, F_AND, F_OR,
      F_XOR, F_NOR, F_SLT: r_alu = 1'b1;
      F_SLL, F_SRL, F_SRA: begin
        r_alu    = 1'b1;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_r   = (opcode == OP_R);
  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_func   = F_ADD;
    illegal    = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            alu_src_b = 2'b01;
            state_d   = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          unique case (1'b1)
            is_mem:                        state_d = S_MEMADR;
            is_r && (funct == F_JR):       state_d = S_JR;
            is_r && r_alu:                 state_d = S_EXEC;
            is_br:                         state_d = S_BRANCH;
            (opcode == OP_ADDI):           state_d = S_ADDIEX;
            (opcode == OP_J):              state_d = S_JUMP;
            default:                       state_d = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_EXEC: begin
          alu_func  = funct;
          alu_src_a = is_shift ? 2'b10 : 2'b01;
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 2'b01;
          alu_func  = F_SUB;
          pc_src    = 2'b01;
          pc_we     = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
          state_d   = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_we  = 1'b1;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          state_d = S_FETCH;
        end
        S_JR: begin
          pc_we   = 1'b1;
          pc_src  = 2'b11;
          state_d = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
          if (!TRAP_ON_ILLEGAL) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Directed bench for mcpu_ctrl_fsm: vector table plus trap and reset sequences.
// Two instances share stimulus, one per TRAP_ON_ILLEGAL setting.
module tb_mcpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;

  logic       pc_we_a, iord_a, mem_rd_a, mem_wr_a, ir_we_a;
  logic       reg_we_a, reg_dst_a, mem_to_reg_a, illegal_a;
  logic [1:0] pc_src_a, alu_src_a_a, alu_src_b_a;
  logic [5:0] alu_func_a;
  logic [3:0] state_a;

  logic       pc_we_b, iord_b, mem_rd_b, mem_wr_b, ir_we_b;
  logic       reg_we_b, reg_dst_b, mem_to_reg_b, illegal_b;
  logic [1:0] pc_src_b, alu_src_a_b, alu_src_b_b;
  logic [5:0] alu_func_b;
  logic [3:0] state_b;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we_a), .pc_src(pc_src_a), .iord(iord_a),
    .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .ir_we(ir_we_a),
    .reg_we(reg_we_a), .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
    .alu_func(alu_func_a), .state(state_a), .illegal(illegal_a)
  );

  mcpu_ctrl_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we_b), .pc_src(pc_src_b), .iord(iord_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .ir_we(ir_we_b),
    .reg_we(reg_we_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_func(alu_func_b), .state(state_b), .illegal(illegal_b)
  );

  // {state, pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_we,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_func, illegal}
  logic [24:0] got_a, got_b;
  assign got_a = {state_a, pc_we_a, pc_src_a, iord_a, mem_rd_a, mem_wr_a,
                  ir_we_a, reg_we_a, reg_dst_a, mem_to_reg_a,
                  alu_src_a_a, alu_src_b_a, alu_func_a, illegal_a};
  assign got_b = {state_b, pc_we_b, pc_src_b, iord_b, mem_rd_b, mem_wr_b,
                  ir_we_b, reg_we_b, reg_dst_b, mem_to_reg_b,
                  alu_src_a_b, alu_src_b_b, alu_func_b, illegal_b};

  function automatic logic [24:0] ev(
    input logic [3:0] st, input logic pcwe, input logic [1:0] pcs,
    input logic io, input logic rd, input logic wr, input logic irw,
    input logic rwe, input logic rdst, input logic m2r,
    input logic [1:0] a, input logic [1:0] b, input logic [5:0] fn,
    input logic ill);
    return {st, pcwe, pcs, io, rd, wr, irw, rwe, rdst, m2r, a, b, fn, ill};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  logic [24:0] RST, FE, FW, DE, MA, RDV, WB4, WR, RW, AX, AW, JP, JRV, TR;

  task automatic chk(input string nm, input logic [24:0] got,
                     input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [24:0] e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
    opcode = op; funct = fn; alu_zero = z; mem_ready = rdy;
  endtask

  initial begin
    RST = ev(0,0,0,0,0,0,0,0,0,0,0,0,ADD,0);
    FE  = ev(0,1,0,0,1,0,1,0,0,0,0,1,ADD,0);
    FW  = ev(0,0,0,0,1,0,0,0,0,0,0,0,ADD,0);
    DE  = ev(1,0,0,0,0,0,0,0,0,0,0,3,ADD,0);
    MA  = ev(2,0,0,0,0,0,0,0,0,0,1,2,ADD,0);
    RDV = ev(3,0,0,1,1,0,0,0,0,0,0,0,ADD,0);
    WB4 = ev(4,0,0,0,0,0,0,1,0,1,0,0,ADD,0);
    WR  = ev(5,0,0,1,0,1,0,0,0,0,0,0,ADD,0);
    RW  = ev(7,0,0,0,0,0,0,1,1,0,0,0,ADD,0);
    AX  = ev(9,0,0,0,0,0,0,0,0,0,1,2,ADD,0);
    AW  = ev(10,0,0,0,0,0,0,1,0,0,0,0,ADD,0);
    JP  = ev(11,1,2,0,0,0,0,0,0,0,0,0,ADD,0);
    JRV = ev(12,1,3,0,0,0,0,0,0,0,0,0,ADD,0);
    TR  = ev(13,0,0,0,0,0,0,0,0,0,0,0,ADD,1);

    // ADD
    add(6'h00, 6'b100000, 0, 1, FE);
    add(6'h00, 6'b100000, 0, 1, DE);
    add(6'h00, 6'b100000, 0, 1, ev(6,0,0,0,0,0,0,0,0,0,1,0,6'b100000,0));
    add(6'h00, 6'b100000, 0, 1, RW);
    // SRA
    add(6'h00, 6'b000011, 0, 1, FE);
    add(6'h00, 6'b000011, 0, 1, DE);
    add(6'h00, 6'b000011, 0, 1, ev(6,0,0,0,0,0,0,0,0,0,2,0,6'b000011,0));
    add(6'h00, 6'b000011, 0, 1, RW);
    // SLT
    add(6'h00, 6'b101010, 0, 1, FE);
    add(6'h00, 6'b101010, 0, 1, DE);
    add(6'h00, 6'b101010, 0, 1, ev(6,0,0,0,0,0,0,0,0,0,1,0,6'b101010,0));
    add(6'h00, 6'b101010, 0, 1, RW);
    // LW with two wait cycles in MEMRD
    add(6'b100011, 6'h00, 0, 1, FE);
    add(6'b100011, 6'h00, 0, 1, DE);
    add(6'b100011, 6'h00, 0, 1, MA);
    add(6'b100011, 6'h00, 0, 0, RDV);
    add(6'b100011, 6'h00, 0, 0, RDV);
    add(6'b100011, 6'h00, 0, 1, RDV);
    add(6'b100011, 6'h00, 0, 1, WB4);
    // SW with one FETCH wait
    add(6'b101011, 6'h00, 0, 0, FW);
    add(6'b101011, 6'h00, 0, 1, FE);
    add(6'b101011, 6'h00, 0, 1, DE);
    add(6'b101011, 6'h00, 0, 1, MA);
    add(6'b101011, 6'h00, 0, 1, WR);
    // BEQ / BNE, both zero values
    add(6'b000100, 6'h00, 1, 1, FE);
    add(6'b000100, 6'h00, 1, 1, DE);
    add(6'b000100, 6'h00, 1, 1, ev(8,1,1,0,0,0,0,0,0,0,1,0,SUB,0));
    add(6'b000101, 6'h00, 1, 1, FE);
    add(6'b000101, 6'h00, 1, 1, DE);
    add(6'b000101, 6'h00, 1, 1, ev(8,0,1,0,0,0,0,0,0,0,1,0,SUB,0));
    add(6'b000100, 6'h00, 0, 1, FE);
    add(6'b000100, 6'h00, 0, 1, DE);
    add(6'b000100, 6'h00, 0, 1, ev(8,0,1,0,0,0,0,0,0,0,1,0,SUB,0));
    add(6'b000101, 6'h00, 0, 1, FE);
    add(6'b000101, 6'h00, 0, 1, DE);
    add(6'b000101, 6'h00, 0, 1, ev(8,1,1,0,0,0,0,0,0,0,1,0,SUB,0));
    // ADDI, J, JR
    add(6'b001000, 6'h00, 0, 1, FE);
    add(6'b001000, 6'h00, 0, 1, DE);
    add(6'b001000, 6'h00, 0, 1, AX);
    add(6'b001000, 6'h00, 0, 1, AW);
    add(6'b000010, 6'h00, 0, 1, FE);
    add(6'b000010, 6'h00, 0, 1, DE);
    add(6'b000010, 6'h00, 0, 1, JP);
    add(6'h00, 6'b001000, 0, 1, FE);
    add(6'h00, 6'b001000, 0, 1, DE);
    add(6'h00, 6'b001000, 0, 1, JRV);

    // reset state, and the idle cycle after release
    rst_n = 1'b0;
    drive(6'h00, 6'h00, 0, 1);
    #1;
    chk("reset_a", got_a, RST);
    chk("reset_b", got_b, RST);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_release_idle", got_a, RST);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].op, vq[i].fn, vq[i].z, vq[i].rdy);
      #1;
      chk($sformatf("vec%0d", i), got_a, vq[i].exp);
    end

    // illegal opcode: lock in one instance, single pulse in the other
    @(negedge clk);
    drive(6'b111111, 6'h00, 0, 1);
    #1 chk("ill_fetch", got_a, FE);
    @(negedge clk);
    #1 chk("ill_decode", got_a, DE);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("trap_a", got_a, TR);
    chk("trap_pulse_b", got_b, TR);
    @(negedge clk);
    #1 chk("pulse_end_b", got_b, FW);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      #1 chk($sformatf("trap_hold%0d", k), got_a, TR);
    end

    // reset clears the trap; then reset during MEMWR
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("trap_reset", got_a, RST);
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b101011, 6'h00, 0, 1);
    @(negedge clk);
    #1 chk("sw_fetch", got_a, FE);
    @(negedge clk);
    #1 chk("sw_decode", got_a, DE);
    @(negedge clk);
    #1 chk("sw_memadr", got_a, MA);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("sw_memwr", got_a, WR);
    #1 rst_n = 1'b0;
    #1;
    chk("memwr_reset_a", got_a, RST);
    chk("memwr_reset_b", got_b, RST);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1 chk("rel_idle", got_a, RST);
    @(negedge clk);
    #1 chk("rel_fetch", got_a, FE);
    @(negedge clk);
    #1 chk("rel_decode", got_a, DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
